// File: rtl/ocl_tile_responder.sv
`timescale 1ns/1ps
// Per-tile OCL slave: one single-beat AW/W or AR at a time, turned into local register strobes.
// Define OCL_RD_TIMEOUT_EN to bound the read-data wait (TIMEOUT_CYCLES, ERR_DATA).
module ocl_tile_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ocl_awvalid,
  output logic        ocl_awready,
  input  logic [31:0] ocl_awaddr,
  input  logic        ocl_wvalid,
  output logic        ocl_wready,
  input  logic [31:0] ocl_wdata,
  output logic        ocl_bvalid,
  input  logic        ocl_bready,
  input  logic        ocl_arvalid,
  output logic        ocl_arready,
  input  logic [31:0] ocl_araddr,
  output logic        ocl_rvalid,
  output logic [31:0] ocl_rdata,
  input  logic        ocl_rready,
  output logic        reg_wvalid,
  output logic [15:0] reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_rvalid,
  output logic [15:0] reg_raddr,
  input  logic        reg_rdata_valid,
  input  logic [31:0] reg_rdata,
  output logic        rd_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_WRITE,
    S_SEND_B,
    S_READ_REQ,
    S_WAIT_RD,
    S_SEND_R
  } state_t;

  state_t      r_state;
  logic [15:0] r_waddr;
  logic [15:0] r_raddr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  // Address bits above the component id are decoded by the fan-out.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^{ocl_awaddr[31:16], ocl_araddr[31:16]};

`ifdef OCL_RD_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_rd_timeout;
  logic        w_expire;
  assign w_expire   = (r_cnt + 32'd1 == TIMEOUT_CYCLES);
  assign rd_timeout = r_rd_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{ERR_DATA, TIMEOUT_CYCLES};
  assign rd_timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_raddr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef OCL_RD_TIMEOUT_EN
      r_cnt        <= '0;
      r_rd_timeout <= 1'b0;
`endif
    end else begin
`ifdef OCL_RD_TIMEOUT_EN
      r_rd_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (ocl_awvalid) begin
            r_waddr <= ocl_awaddr[15:0];
            r_state <= S_WAIT_W;
          end else if (ocl_arvalid) begin
            r_raddr <= ocl_araddr[15:0];
            r_state <= S_READ_REQ;
`ifdef OCL_RD_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_WAIT_W: begin
          if (ocl_wvalid) begin
            r_wdata <= ocl_wdata;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: r_state <= S_SEND_B;
        S_SEND_B: begin
          if (ocl_bready) r_state <= S_IDLE;
        end
        // Component data is accepted in the request cycle too (zero-latency components).
        S_READ_REQ, S_WAIT_RD: begin
          if (reg_rdata_valid) begin
            r_rdata <= reg_rdata;
            r_state <= S_SEND_R;
          end
`ifdef OCL_RD_TIMEOUT_EN
          else if (w_expire) begin
            r_rdata      <= ERR_DATA;
            r_rd_timeout <= 1'b1;
            r_state      <= S_SEND_R;
          end else begin
            r_cnt   <= r_cnt + 32'd1;
            r_state <= S_WAIT_RD;
          end
`else
          else begin
            r_state <= S_WAIT_RD;
          end
`endif
        end
        S_SEND_R: begin
          if (ocl_rready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ocl_awready = (r_state == S_IDLE);
  assign ocl_arready = (r_state == S_IDLE);
  assign ocl_wready  = (r_state == S_WAIT_W);
  assign ocl_bvalid  = (r_state == S_SEND_B);
  assign ocl_rvalid  = (r_state == S_SEND_R);
  assign ocl_rdata   = r_rdata;
  assign reg_wvalid  = (r_state == S_WRITE);
  assign reg_rvalid  = (r_state == S_READ_REQ);
  assign reg_waddr   = r_waddr;
  assign reg_wdata   = r_wdata;
  assign reg_raddr   = r_raddr;

endmodule
